pipeline_sequencer: RTL and testbench

//  Run/halt sequencer and hazard controller for the 5-stage MIPS pipeline (IF/ID/EX/MEM/WB).

---
 rtl/pipe_ctrl_pkg.sv | 15 +
 rtl/load_use_detect.sv | 16 +
 rtl/pipeline_sequencer.sv | 129 ++++++++++++
 tb/tb_pipeline_sequencer.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the MIPS pipeline run/halt sequencer: state encoding,
// register-address width and the default drain depth.
package pipe_ctrl_pkg;

  localparam int REG_ADDR_W          = 5;
  localparam int DEFAULT_DRAIN_DEPTH = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard comparator: flags an instruction in ID that reads the
// destination of a load currently in EX. Register $zero never creates a hazard.
module load_use_detect
  import pipe_ctrl_pkg::*;
(
  input  logic                  ex_memread_i,
  input  logic [REG_ADDR_W-1:0] ex_rt_i,
  input  logic [REG_ADDR_W-1:0] id_rs_i,
  input  logic [REG_ADDR_W-1:0] id_rt_i,
  output logic                  stall_o
);

  assign stall_o = ex_memread_i && (ex_rt_i != '0) &&
                   ((ex_rt_i == id_rs_i) || (ex_rt_i == id_rt_i));

endmodule

// File: rtl/pipeline_sequencer.sv
// Run/halt sequencer and hazard controller for the 5-stage MIPS pipeline.
// Define PIPE_PERF_CNT_EN to export the cycle/stall/flush counters; otherwise they read 0.
module pipeline_sequencer
  import pipe_ctrl_pkg::*;
#(
  parameter int MAX_CYCLES  = 30,
  parameter int DRAIN_DEPTH = DEFAULT_DRAIN_DEPTH,
  parameter int CNT_W       = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic                  halt_i,
  input  logic [REG_ADDR_W-1:0] id_rs_i,
  input  logic [REG_ADDR_W-1:0] id_rt_i,
  input  logic                  ex_memread_i,
  input  logic [REG_ADDR_W-1:0] ex_rt_i,
  input  logic                  branch_taken_i,
  input  logic                  jump_i,
  output logic                  pc_write_o,
  output logic                  ifid_write_o,
  output logic                  ifid_flush_o,
  output logic                  idex_bubble_o,
  output logic                  running_o,
  output logic                  done_o,
  output logic [CNT_W-1:0]      cycle_cnt_o,
  output logic [CNT_W-1:0]      stall_cnt_o,
  output logic [CNT_W-1:0]      flush_cnt_o
);

  localparam int                DRAIN_W    = (DRAIN_DEPTH > 1) ? $clog2(DRAIN_DEPTH) : 1;
  localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DRAIN_DEPTH - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);

  state_e               state_q, state_d;
  logic                 stall;
  logic                 max_hit;
  logic                 run_start;
  logic [DRAIN_W-1:0]   drain_cnt_q;
  logic [CNT_W-1:0]     cycle_cnt_q;

  load_use_detect u_load_use_detect (
    .ex_memread_i (ex_memread_i),
    .ex_rt_i      (ex_rt_i),
    .id_rs_i      (id_rs_i),
    .id_rt_i      (id_rt_i),
    .stall_o      (stall)
  );

  // The RUN cycle that reaches MAX_CYCLES-1 is the last one; it still counts.
  assign max_hit   = (MAX_CYCLES != 0) && (cycle_cnt_q == CNT_W'(MAX_CYCLES - 1));
  assign run_start = (state_q == IDLE) && start_i;
  assign running_o = (state_q == RUN);
  assign done_o    = (state_q == DONE);

  // NOTE: every signal driven here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    state_d       = state_q;
    pc_write_o    = 1'b0;
    ifid_write_o  = 1'b0;
    ifid_flush_o  = 1'b0;
    idex_bubble_o = 1'b1;
    case (state_q)
      IDLE: if (start_i) state_d = RUN;
      RUN: begin
        if (!stall) begin
          pc_write_o    = 1'b1;
          ifid_write_o  = 1'b1;
          idex_bubble_o = 1'b0;
          ifid_flush_o  = branch_taken_i || jump_i;
        end
        if (halt_i || !start_i || max_hit) state_d = DRAIN;
      end
      DRAIN: begin
        ifid_write_o  = 1'b1;
        ifid_flush_o  = 1'b1;
        idex_bubble_o = 1'b0;
        if (drain_cnt_q == DRAIN_LAST) state_d = DONE;
      end
      DONE: if (!start_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of process ordering.
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || (state_q != DRAIN)) drain_cnt_q <= '0;
    else                             drain_cnt_q <= drain_cnt_q + DRAIN_W'(1);
  end

  // Kept even without perf counters: the auto-drain limit depends on it.
  always_ff @(posedge clk_i) begin
    if (rst_i || run_start)
      cycle_cnt_q <= '0;
    else if ((state_q == RUN) && (cycle_cnt_q != '1))
      cycle_cnt_q <= cycle_cnt_q + CNT_ONE;
  end

`ifdef PIPE_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] flush_cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i || run_start) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else if (state_q == RUN) begin
      if (stall && (stall_cnt_q != '1))        stall_cnt_q <= stall_cnt_q + CNT_ONE;
      if (ifid_flush_o && (flush_cnt_q != '1)) flush_cnt_q <= flush_cnt_q + CNT_ONE;
    end
  end

  assign cycle_cnt_o = cycle_cnt_q;
  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;
`else
  assign cycle_cnt_o = '0;
  assign stall_cnt_o = '0;
  assign flush_cnt_o = '0;
`endif

endmodule

// File: tb/tb_pipeline_sequencer.sv
// Directed bench for pipeline_sequencer: reset, hazard responses, halt drain,
// MAX_CYCLES auto-drain, reset during drain and start release.
module tb_pipeline_sequencer;

`ifdef PIPE_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        start_i;
  logic        halt_i;
  logic [4:0]  id_rs_i;
  logic [4:0]  id_rt_i;
  logic        ex_memread_i;
  logic [4:0]  ex_rt_i;
  logic        branch_taken_i;
  logic        jump_i;
  logic        pc_write_o;
  logic        ifid_write_o;
  logic        ifid_flush_o;
  logic        idex_bubble_o;
  logic        running_o;
  logic        done_o;
  logic [31:0] cycle_cnt_o;
  logic [31:0] stall_cnt_o;
  logic [31:0] flush_cnt_o;

  logic [3:0]  ctrl;
  logic [1:0]  st;
  int          total = 0;
  int          bad   = 0;

  assign ctrl = {pc_write_o, ifid_write_o, ifid_flush_o, idex_bubble_o};
  assign st   = {running_o, done_o};

  pipeline_sequencer dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .start_i        (start_i),
    .halt_i         (halt_i),
    .id_rs_i        (id_rs_i),
    .id_rt_i        (id_rt_i),
    .ex_memread_i   (ex_memread_i),
    .ex_rt_i        (ex_rt_i),
    .branch_taken_i (branch_taken_i),
    .jump_i         (jump_i),
    .pc_write_o     (pc_write_o),
    .ifid_write_o   (ifid_write_o),
    .ifid_flush_o   (ifid_flush_o),
    .idex_bubble_o  (idex_bubble_o),
    .running_o      (running_o),
    .done_o         (done_o),
    .cycle_cnt_o    (cycle_cnt_o),
    .stall_cnt_o    (stall_cnt_o),
    .flush_cnt_o    (flush_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  // Counter ports read 0 unless the perf counters are built in.
  function automatic logic [31:0] pv(input int v);
    return PERF ? 32'(v) : 32'd0;
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic clear_hazard();
    halt_i = 0; id_rs_i = 0; id_rt_i = 0; ex_memread_i = 0;
    ex_rt_i = 0; branch_taken_i = 0; jump_i = 0;
    #1;
  endtask

  task automatic test_reset();
    rst_i = 1; start_i = 0; halt_i = 1; id_rs_i = 5'd8; id_rt_i = 5'd8;
    ex_memread_i = 1; ex_rt_i = 5'd8; branch_taken_i = 1; jump_i = 1;
    tick(); tick();
    rst_i = 0;
    clear_hazard();
    total++; if (ctrl !== 4'b0001) begin bad++; $display("FAIL reset_ctrl got=%b exp=0001", ctrl); end
    total++; if (st !== 2'b00) begin bad++; $display("FAIL reset_state got=%b exp=00", st); end
    total++; if ({cycle_cnt_o, stall_cnt_o, flush_cnt_o} !== 96'd0) begin
      bad++; $display("FAIL reset_cnt got=%0d/%0d/%0d exp=0/0/0", cycle_cnt_o, stall_cnt_o, flush_cnt_o);
    end
  endtask

  // Leaves the sequencer in RUN with cycle_cnt = 3.
  task automatic test_run_start();
    start_i = 1; #1;
    total++; if (ctrl !== 4'b0001) begin bad++; $display("FAIL idle_ctrl got=%b exp=0001", ctrl); end
    tick();
    total++; if (st !== 2'b10) begin bad++; $display("FAIL run_entry got=%b exp=10", st); end
    total++; if (ctrl !== 4'b1100) begin bad++; $display("FAIL run_ctrl got=%b exp=1100", ctrl); end
    for (int i = 1; i <= 3; i++) begin
      tick();
      total++; if (cycle_cnt_o !== pv(i)) begin bad++; $display("FAIL run_cycle got=%0d exp=%0d", cycle_cnt_o, pv(i)); end
    end
  endtask

  // cycle_cnt 3 -> 7, stall_cnt 0 -> 2.
  task automatic test_load_use();
    ex_memread_i = 1; ex_rt_i = 5'd8; id_rs_i = 5'd8; id_rt_i = 5'd1; #1;
    total++; if (ctrl !== 4'b0001) begin bad++; $display("FAIL lu_rs_ctrl got=%b exp=0001", ctrl); end
    tick();
    total++; if (stall_cnt_o !== pv(1)) begin bad++; $display("FAIL lu_rs_cnt got=%0d exp=%0d", stall_cnt_o, pv(1)); end
    ex_rt_i = 5'd0; id_rs_i = 5'd0; id_rt_i = 5'd0; #1;
    total++; if (ctrl !== 4'b1100) begin bad++; $display("FAIL lu_zero_ctrl got=%b exp=1100", ctrl); end
    tick();
    ex_rt_i = 5'd9; id_rs_i = 5'd3; id_rt_i = 5'd9; #1;
    total++; if (ctrl !== 4'b0001) begin bad++; $display("FAIL lu_rt_ctrl got=%b exp=0001", ctrl); end
    tick();
    ex_memread_i = 0; #1;
    total++; if (ctrl !== 4'b1100) begin bad++; $display("FAIL lu_noload_ctrl got=%b exp=1100", ctrl); end
    tick();
    total++; if ({cycle_cnt_o, stall_cnt_o} !== {pv(7), pv(2)}) begin
      bad++; $display("FAIL lu_cnt got=%0d/%0d exp=%0d/%0d", cycle_cnt_o, stall_cnt_o, pv(7), pv(2));
    end
    clear_hazard();
  endtask

  // cycle_cnt 7 -> 9, stall_cnt 3, flush_cnt 1.
  task automatic test_stall_branch();
    ex_memread_i = 1; ex_rt_i = 5'd8; id_rs_i = 5'd8; branch_taken_i = 1; #1;
    total++; if (ctrl !== 4'b0001) begin bad++; $display("FAIL sb_prio_ctrl got=%b exp=0001", ctrl); end
    tick();
    ex_memread_i = 0; #1;
    total++; if (ctrl !== 4'b1110) begin bad++; $display("FAIL sb_branch_ctrl got=%b exp=1110", ctrl); end
    tick();
    total++; if ({stall_cnt_o, flush_cnt_o} !== {pv(3), pv(1)}) begin
      bad++; $display("FAIL sb_cnt got=%0d/%0d exp=%0d/%0d", stall_cnt_o, flush_cnt_o, pv(3), pv(1));
    end
    clear_hazard();
  endtask

  // Halt in the 10th RUN cycle, drain 4 cycles, then DONE with counters held.
  task automatic test_halt_drain();
    halt_i = 1; #1;
    total++; if (ctrl !== 4'b1100) begin bad++; $display("FAIL halt_ctrl got=%b exp=1100", ctrl); end
    tick();
    halt_i = 0; jump_i = 1; #1;
    for (int i = 0; i < 4; i++) begin
      total++; if ({st, ctrl} !== 6'b00_0110) begin bad++; $display("FAIL drain_%0d got=%b exp=000110", i, {st, ctrl}); end
      tick();
    end
    jump_i = 0; #1;
    total++; if ({st, ctrl} !== 6'b01_0001) begin bad++; $display("FAIL done_entry got=%b exp=010001", {st, ctrl}); end
    total++; if ({cycle_cnt_o, flush_cnt_o} !== {pv(10), pv(1)}) begin
      bad++; $display("FAIL done_cnt got=%0d/%0d exp=%0d/%0d", cycle_cnt_o, flush_cnt_o, pv(10), pv(1));
    end
    tick();
    total++; if (st !== 2'b01) begin bad++; $display("FAIL done_hold got=%b exp=01", st); end
    start_i = 0;
    tick();
    total++; if ({st, cycle_cnt_o} !== {2'b00, pv(10)}) begin
      bad++; $display("FAIL idle_hold got=%b/%0d exp=00/%0d", st, cycle_cnt_o, pv(10));
    end
  endtask

  task automatic test_max_cycles_reset();
    start_i = 1;
    tick();
    total++; if ({cycle_cnt_o, stall_cnt_o, flush_cnt_o} !== 96'd0) begin
      bad++; $display("FAIL restart_clear got=%0d/%0d/%0d exp=0/0/0", cycle_cnt_o, stall_cnt_o, flush_cnt_o);
    end
    repeat (29) tick();
    total++; if ({st, cycle_cnt_o} !== {2'b10, pv(29)}) begin
      bad++; $display("FAIL max_pre got=%b/%0d exp=10/%0d", st, cycle_cnt_o, pv(29));
    end
    tick();
    total++; if ({st, ctrl, cycle_cnt_o} !== {6'b00_0110, pv(30)}) begin
      bad++; $display("FAIL max_drain got=%b/%0d exp=000110/%0d", {st, ctrl}, cycle_cnt_o, pv(30));
    end
    tick();
    rst_i = 1;
    tick();
    rst_i = 0; #1;
    total++; if ({st, ctrl, cycle_cnt_o} !== {6'b00_0001, 32'd0}) begin
      bad++; $display("FAIL drain_reset got=%b/%0d exp=000001/0", {st, ctrl}, cycle_cnt_o);
    end
  endtask

  // halt_i coincides with the MAX_CYCLES limit: one transition, one count.
  task automatic test_halt_at_max();
    tick();
    repeat (29) tick();
    halt_i = 1;
    tick();
    halt_i = 0; #1;
    total++; if ({st, ctrl, cycle_cnt_o} !== {6'b00_0110, pv(30)}) begin
      bad++; $display("FAIL both_drain got=%b/%0d exp=000110/%0d", {st, ctrl}, cycle_cnt_o, pv(30));
    end
    repeat (3) tick();
    total++; if (st !== 2'b00) begin bad++; $display("FAIL both_drain_len got=%b exp=00", st); end
    tick();
    total++; if ({st, cycle_cnt_o} !== {2'b01, pv(30)}) begin
      bad++; $display("FAIL both_done got=%b/%0d exp=01/%0d", st, cycle_cnt_o, pv(30));
    end
  endtask

  task automatic test_start_drop();
    start_i = 0;
    tick();
    start_i = 1;
    tick();
    tick();
    start_i = 0; #1;
    total++; if ({st, ctrl} !== 6'b10_1100) begin bad++; $display("FAIL drop_run got=%b exp=101100", {st, ctrl}); end
    tick();
    total++; if ({st, ctrl, cycle_cnt_o} !== {6'b00_0110, pv(2)}) begin
      bad++; $display("FAIL drop_drain got=%b/%0d exp=000110/%0d", {st, ctrl}, cycle_cnt_o, pv(2));
    end
  endtask

  initial begin
    test_reset();
    test_run_start();
    test_load_use();
    test_stall_branch();
    test_halt_drain();
    test_max_cycles_reset();
    test_halt_at_max();
    test_start_drop();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
